// File: rtl/fiber_frame_unpacker_pkg.sv
// rtl/fiber_frame_unpacker_pkg.sv - shared fiber frame definitions (header layout, markers, fsm states)
package fiber_frame_unpacker_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hA5C3;
  localparam int          WORD_W        = 32;
  localparam int          SAMPLE_W_DEF  = 12;
  localparam int          HDR_SYNC_LSB  = 16;
  localparam int          HDR_CTRL_LSB  = 8;
  localparam int          HDR_SEQ_LSB   = 0;
  localparam int          PAY_MARK_LSB  = 24;
  localparam logic [7:0]  PAYLOAD_MARK  = 8'h00;
  localparam logic [15:0] CNT_MAX       = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_HEADER  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WC_HEADER,
    WC_PAYLOAD,
    WC_BAD
  } word_class_t;

  // Header check wins: a sync word can never also look like payload.
  function automatic word_class_t classify(input logic [WORD_W-1:0] w, input logic [15:0] sync);
    if (w[HDR_SYNC_LSB +: 16] == sync) return WC_HEADER;
    if (w[PAY_MARK_LSB +: 8] == PAYLOAD_MARK) return WC_PAYLOAD;
    return WC_BAD;
  endfunction

endpackage

// File: rtl/fiber_frame_unpacker_if.sv
// rtl/fiber_frame_unpacker_if.sv - fifo read side and sample output stream of the deframer
interface fiber_frame_unpacker_if
  import fiber_frame_unpacker_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF
) ();

  logic                fifo_rd_en;
  logic [WORD_W-1:0]   fifo_rd_data;
  logic                fifo_empty;
  logic                sample_valid;
  logic [SAMPLE_W-1:0] sample_a;
  logic [SAMPLE_W-1:0] sample_b;
  logic                frame_start;

  modport master (
    output fifo_rd_en, sample_valid, sample_a, sample_b, frame_start,
    input  fifo_rd_data, fifo_empty
  );

  modport slave (
    input  fifo_rd_en, sample_valid, sample_a, sample_b, frame_start,
    output fifo_rd_data, fifo_empty
  );

endinterface

// File: rtl/fiber_frame_unpacker_sat_cnt16.sv
// rtl/fiber_frame_unpacker_sat_cnt16.sv - 16-bit saturating event counter, clear beats increment
module sat_cnt16
  import fiber_frame_unpacker_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  input  logic        clr,
  output logic [15:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: rtl/fiber_frame_unpacker.sv
// rtl/fiber_frame_unpacker.sv - receive deframer: fifo words to paired adc samples, lock and error tracking
module fiber_frame_unpacker
  import fiber_frame_unpacker_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter int          FRAME_LEN   = 64,
  parameter int          LOCK_FRAMES = 4,
  parameter int          SAMPLE_W    = SAMPLE_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fiber_frame_unpacker_if.master bus,
  input  logic                   clr_cnt,
  output logic [7:0]             ctrl_word,
  output logic [7:0]             seq_num,
  output logic                   locked,
  output logic [15:0]            frame_err_cnt,
  output logic [15:0]            seq_err_cnt
);

  localparam logic [7:0] LAST_WORD = 8'(FRAME_LEN - 1);
  localparam logic [3:0] LOCK_CNT  = 4'(LOCK_FRAMES);

  state_t      state_q, state_d;
  word_class_t wclass;
  logic        word_vld;
  logic [7:0]  wcnt_q, wcnt_d;
  logic [3:0]  good_q, good_d;
  logic        locked_d;
  logic [7:0]  ctrl_d, seq_d, hdr_ctrl, hdr_seq;
  logic        smp_d, fstart_d, frame_err_inc, seq_err_inc;

  assign bus.fifo_rd_en = !bus.fifo_empty;
  assign wclass         = classify(bus.fifo_rd_data, SYNC_WORD);
  assign hdr_ctrl       = bus.fifo_rd_data[HDR_CTRL_LSB +: 8];
  assign hdr_seq        = bus.fifo_rd_data[HDR_SEQ_LSB +: 8];

  always_comb begin
    state_d       = state_q;
    wcnt_d        = wcnt_q;
    good_d        = good_q;
    locked_d      = locked;
    ctrl_d        = ctrl_word;
    seq_d         = seq_num;
    smp_d         = 1'b0;
    fstart_d      = 1'b0;
    frame_err_inc = 1'b0;
    seq_err_inc   = 1'b0;
    if (word_vld) begin
      case (state_q)
        ST_HUNT: begin
          if (wclass == WC_HEADER) begin
            ctrl_d  = hdr_ctrl;
            seq_d   = hdr_seq;
            good_d  = '0;
            wcnt_d  = '0;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (wclass == WC_PAYLOAD) begin
            smp_d    = 1'b1;
            fstart_d = (wcnt_q == 8'd0);
            wcnt_d   = wcnt_q + 8'd1;
            if (wcnt_q == LAST_WORD) state_d = ST_HEADER;
          end else begin
            frame_err_inc = 1'b1;
            locked_d      = 1'b0;
            good_d        = '0;
            // A header arriving early restarts the frame instead of rehunting.
            if (wclass == WC_HEADER) begin
              ctrl_d = hdr_ctrl;
              seq_d  = hdr_seq;
              wcnt_d = '0;
            end else begin
              state_d = ST_HUNT;
            end
          end
        end
        ST_HEADER: begin
          if (wclass == WC_HEADER) begin
            seq_err_inc = (hdr_seq != seq_num + 8'd1);
            ctrl_d      = hdr_ctrl;
            seq_d       = hdr_seq;
            wcnt_d      = '0;
            state_d     = ST_PAYLOAD;
            if (good_q != LOCK_CNT) good_d = good_q + 4'd1;
            locked_d    = (good_d == LOCK_CNT);
          end else begin
            frame_err_inc = 1'b1;
            locked_d      = 1'b0;
            good_d        = '0;
            state_d       = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= ST_HUNT;
      word_vld         <= 1'b0;
      wcnt_q           <= '0;
      good_q           <= '0;
      locked           <= 1'b0;
      ctrl_word        <= '0;
      seq_num          <= '0;
      bus.sample_valid <= 1'b0;
      bus.frame_start  <= 1'b0;
      bus.sample_a     <= '0;
      bus.sample_b     <= '0;
    end else begin
      state_q          <= state_d;
      word_vld         <= bus.fifo_rd_en;
      wcnt_q           <= wcnt_d;
      good_q           <= good_d;
      locked           <= locked_d;
      ctrl_word        <= ctrl_d;
      seq_num          <= seq_d;
      bus.sample_valid <= smp_d;
      bus.frame_start  <= fstart_d;
      if (smp_d) begin
        bus.sample_a <= bus.fifo_rd_data[SAMPLE_W-1:0];
        bus.sample_b <= bus.fifo_rd_data[2*SAMPLE_W-1:SAMPLE_W];
      end
    end
  end

  sat_cnt16 u_frame_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_err_inc),
    .clr   (clr_cnt),
    .cnt   (frame_err_cnt)
  );

  sat_cnt16 u_seq_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (seq_err_inc),
    .clr   (clr_cnt),
    .cnt   (seq_err_cnt)
  );

endmodule

// File: tb/tb_fiber_frame_unpacker.sv
// tb/tb_fiber_frame_unpacker.sv - directed table-driven bench for fiber_frame_unpacker
module tb_fiber_frame_unpacker;
  import fiber_frame_unpacker_pkg::*;

  typedef struct packed {
    logic [31:0] w;
    logic        smp;
    logic        fs;
  } ent_t;

  typedef struct packed {
    logic [31:0] w;
    logic        fs;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] hdr;
    int          garbage;
    int          npay;
    int          bad_at;
    bit          smp;
    bit          gaps;
    bit          exp_locked;
    logic [15:0] exp_ferr;
    logic [15:0] exp_serr;
    logic [7:0]  exp_ctrl;
    logic [7:0]  exp_seq;
  } vec_t;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        empty_r = 1'b1;
  logic [31:0] rd_data = '0;
  bit          gap     = 1'b1;
  logic [7:0]  ctrl_word, seq_num;
  logic        locked;
  logic [15:0] frame_err_cnt, seq_err_cnt;
  int          cyc   = 0;
  int          nsmp  = 0;
  int          total = 0;
  int          bad   = 0;
  ent_t        wq[$];
  exp_t        eq[$];
  vec_t        vecs[16];

  fiber_frame_unpacker_if #(.SAMPLE_W(12)) bus ();
  assign bus.fifo_empty   = empty_r;
  assign bus.fifo_rd_data = rd_data;

  fiber_frame_unpacker dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .clr_cnt       (clr_cnt),
    .ctrl_word     (ctrl_word),
    .seq_num       (seq_num),
    .locked        (locked),
    .frame_err_cnt (frame_err_cnt),
    .seq_err_cnt   (seq_err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic smp, input logic fs);
    wq.push_back('{w: w, smp: smp, fs: fs});
  endtask

  function automatic logic [31:0] pay(input int i);
    return {8'h00, 12'(12'h800 + i), 12'(12'h100 + i)};
  endfunction

  task automatic drain(input bit gaps, input int budget);
    int n = 0;
    while (wq.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
      if (gaps && (n % 3 == 0)) gap = ~gap;
    end
    gap = 1'b0;
    check("drain_words_left", wq.size(), 0);
    wq.delete();
    repeat (4) @(posedge clk);
    #2;
  endtask

  // FIFO with one-cycle read latency; each read records when its sample is due.
  always @(posedge clk) begin : fifo_model
    ent_t e;
    cyc <= cyc + 1;
    if (bus.fifo_rd_en && wq.size() != 0) begin
      e = wq.pop_front();
      rd_data <= e.w;
      if (e.smp) eq.push_back('{w: e.w, fs: e.fs, due: cyc + 2});
    end
  end

  always @(negedge clk) begin : scoreboard
    exp_t x;
    empty_r = (wq.size() == 0) || gap;
    if (rst_n && bus.sample_valid) begin
      nsmp++;
      if (eq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sample_unexpected: got a=%0h b=%0h want no sample", bus.sample_a, bus.sample_b);
      end else begin
        x = eq.pop_front();
        check("sample_data", {8'h00, bus.sample_b, bus.sample_a}, {8'h00, x.w[23:0]});
        check("frame_start", {31'd0, bus.frame_start}, {31'd0, x.fs});
        check("sample_latency", cyc, x.due);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          hdr            garb npay bad  smp   gaps  lk    ferr    serr    ctrl   seq
    vecs[0]  = '{32'hA5C3_0100, 10, 64, -1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 8'h01, 8'h00};
    vecs[1]  = '{32'hA5C3_0101,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 8'h01, 8'h01};
    vecs[2]  = '{32'hA5C3_0102,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 8'h01, 8'h02};
    vecs[3]  = '{32'hA5C3_0103,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 8'h01, 8'h03};
    vecs[4]  = '{32'hA5C3_0104,  0, 64, -1, 1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'h01, 8'h04};
    vecs[5]  = '{32'hA5C3_0105,  0, 64, 20, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 8'h01, 8'h05};
    vecs[6]  = '{32'hA5C3_010C,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 8'h01, 8'h0C};
    vecs[7]  = '{32'hA5C3_010D,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 8'h01, 8'h0D};
    vecs[8]  = '{32'hA5C3_010E,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 8'h01, 8'h0E};
    vecs[9]  = '{32'hA5C3_010F,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd1, 16'd0, 8'h01, 8'h0F};
    vecs[10] = '{32'hA5C3_0110,  0, 64, -1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd0, 8'h01, 8'h10};
    vecs[11] = '{32'hA5C3_0012,  0, 64, -1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 8'h00, 8'h12};
    vecs[12] = '{32'hA5C3_0113,  0, 64, -1, 1'b1, 1'b1, 1'b1, 16'd1, 16'd1, 8'h01, 8'h13};
    vecs[13] = '{32'hA5C3_0114,  0, 10, -1, 1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 8'h01, 8'h14};
    vecs[14] = '{32'hA5C3_0115,  0, 64, -1, 1'b1, 1'b0, 1'b0, 16'd2, 16'd1, 8'h01, 8'h15};
    vecs[15] = '{32'h0000_0000,  0,  1, -1, 1'b0, 1'b0, 1'b0, 16'd3, 16'd1, 8'h01, 8'h15};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sample_valid", {31'd0, bus.sample_valid}, 32'd0);
    check("rst_frame_start", {31'd0, bus.frame_start}, 32'd0);
    check("rst_samples", {8'h00, bus.sample_b, bus.sample_a}, 32'd0);
    check("rst_locked", {31'd0, locked}, 32'd0);
    check("rst_ctrl_seq", {16'd0, ctrl_word, seq_num}, 32'd0);
    check("rst_frame_err", {16'd0, frame_err_cnt}, 32'd0);
    check("rst_seq_err", {16'd0, seq_err_cnt}, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    gap   = 1'b0;

    for (int r = 0; r < 16; r++) begin
      @(posedge clk); #2;
      for (int g = 0; g < vecs[r].garbage; g++) push(32'hDEADBEEF, 1'b0, 1'b0);
      if (vecs[r].hdr != 32'd0) push(vecs[r].hdr, 1'b0, 1'b0);
      for (int i = 0; i < vecs[r].npay; i++) begin
        if (i == vecs[r].bad_at) push(32'h5A12_3456, 1'b0, 1'b0);
        else push(pay(i), vecs[r].smp && (vecs[r].bad_at < 0 || i < vecs[r].bad_at), i == 0);
      end
      drain(vecs[r].gaps, 3000);
      @(negedge clk);
      check($sformatf("v%0d_locked", r), {31'd0, locked}, {31'd0, vecs[r].exp_locked});
      check($sformatf("v%0d_frame_err", r), {16'd0, frame_err_cnt}, {16'd0, vecs[r].exp_ferr});
      check($sformatf("v%0d_seq_err", r), {16'd0, seq_err_cnt}, {16'd0, vecs[r].exp_serr});
      check($sformatf("v%0d_ctrl", r), {24'd0, ctrl_word}, {24'd0, vecs[r].exp_ctrl});
      check($sformatf("v%0d_seq", r), {24'd0, seq_num}, {24'd0, vecs[r].exp_seq});
      if (r == 4) check("sample_count_5frames", nsmp, 320);
    end

    // Back-to-back headers: each one after the first is a short frame.
    @(posedge clk); #2;
    for (int i = 0; i < 65533; i++) push(32'hA5C3_0200, 1'b0, 1'b0);
    drain(1'b0, 70000);
    @(negedge clk);
    check("sat_frame_err_reach", {16'd0, frame_err_cnt}, 32'h0000_FFFF);
    check("sat_ctrl", {24'd0, ctrl_word}, 32'h0000_0002);
    check("sat_seq_err_kept", {16'd0, seq_err_cnt}, 32'd1);
    @(posedge clk); #2;
    push(32'hA5C3_0201, 1'b0, 1'b0);
    drain(1'b0, 100);
    @(negedge clk);
    check("sat_frame_err_hold", {16'd0, frame_err_cnt}, 32'h0000_FFFF);

    // clr_cnt on the same edge as a short-frame error.
    @(posedge clk); #2;
    gap = 1'b1;
    push(32'hA5C3_0202, 1'b0, 1'b0);
    @(posedge clk); #2;
    gap = 1'b0;
    @(posedge clk); #2;
    clr_cnt = 1'b1;
    gap     = 1'b1;
    @(posedge clk); #2;
    clr_cnt = 1'b0;
    @(negedge clk);
    check("clr_vs_inc_frame_err", {16'd0, frame_err_cnt}, 32'd0);
    check("clr_seq_err", {16'd0, seq_err_cnt}, 32'd0);
    check("clr_took_header_seq", {24'd0, seq_num}, 32'h0000_0002);

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("samples_missing", eq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fiber_frame_unpacker.md
Name: fiber_frame_unpacker

Overview:
- Receive-side deframer for the optical-fiber link.
- Drains 32-bit words from the fiber receive FIFO (show-ahead off, 1-cycle read latency) and finds frame headers.
- Splits payload words back into paired 12-bit ADC samples (channel A, channel B) and extracts the per-frame control byte; ctrl_word[0] drives the ADC/inu clock select downstream.
- Also tracks lock state and framing/sequence error counts for software via GPIO/status.

Parameters:
- SYNC_WORD, 16'hA5C3, header marker in word bits [31:16]
- FRAME_LEN, 64, payload words per frame (2..255)
- LOCK_FRAMES, 4, consecutive good frames required to assert locked (1..15)
- SAMPLE_W, 12, sample width per channel; payload bits [2*SAMPLE_W-1:0] = {B, A}

Ports:
- clk  in  1  system clock, also the FIFO read clock
- rst_n  in  1  asynchronous active-low reset
- fifo_rd_en  out  1  FIFO read strobe
- fifo_rd_data  in  32  FIFO read data, valid 1 cycle after fifo_rd_en
- fifo_empty  in  1  FIFO empty/almost-empty flag
- clr_cnt  in  1  synchronous clear of both error counters
- sample_valid  out  1  one-cycle strobe; sample_a/sample_b valid
- sample_a  out  12  channel A sample (payload [11:0])
- sample_b  out  12  channel B sample (payload [23:12])
- frame_start  out  1  high with the first sample_valid of each frame
- ctrl_word  out  8  control byte of last accepted header
- seq_num  out  8  sequence byte of last accepted header
- locked  out  1  link framing locked
- frame_err_cnt  out  16  saturating framing-error count
- seq_err_cnt  out  16  saturating sequence-error count

Behaviour:
- Reset (async, rst_n=0): all outputs 0; FSM=HUNT; counters 0.
- Read side:
  - fifo_rd_en = !fifo_empty in every state; no downstream backpressure.
  - A 1-bit pipeline flag word_vld = registered fifo_rd_en marks fifo_rd_data as valid.
  - All decisions are taken only on word_vld cycles.
- Word classes:
  - Header: [31:16]==SYNC_WORD; [15:8]=ctrl; [7:0]=seq.
  - Payload: [31:24]==8'h00.
  - Anything else is a bad word.
- FSM HUNT: header -> capture ctrl_word/seq_num, good_cnt=0, wcnt=0, go PAYLOAD. Other words are discarded; no error is counted.
- FSM PAYLOAD, on word_vld:
  - Payload word: sample_valid=1 next cycle with sample_a/sample_b registered; frame_start=1 if wcnt==0; wcnt++. At wcnt==FRAME_LEN-1 -> go HEADER.
  - Header word (short frame): frame_err_cnt++, locked=0, good_cnt=0, accept it as a new header (capture ctrl/seq, wcnt=0), stay PAYLOAD.
  - Bad word: frame_err_cnt++, locked=0, good_cnt=0, go HUNT.
- FSM HEADER, on word_vld:
  - Header word: frame is good.
    - If seq != seq_num+1 (mod 256): seq_err_cnt++; frame is still accepted.
    - Capture ctrl_word/seq_num, wcnt=0, go PAYLOAD.
    - good_cnt saturates at LOCK_FRAMES; locked=1 once good_cnt reaches LOCK_FRAMES.
  - Other word (long frame or bad word): frame_err_cnt++, locked=0, good_cnt=0, go HUNT.
- Samples are emitted regardless of locked; consumers qualify them with locked.
- Latency: fifo_rd_en -> sample_valid is 2 cycles (1 FIFO read latency + 1 output register).
- fifo_empty mid-frame: no word_vld, so the FSM holds and wcnt holds. No timeout.
- Error counters:
  - Saturate at 16'hFFFF.
  - clr_cnt clears both next cycle; clr_cnt wins over a simultaneous increment.
- ctrl_word and seq_num update only on an accepted header. They keep their values in HUNT and through loss of lock.

Decomposition:
- Shared package/header (fiber_frame_defs): SYNC_WORD default, header field offsets, payload marker 8'h00, FSM state encodings (HUNT=0, PAYLOAD=1, HEADER=2).
- The packer on the transmit side includes the same defs.
- One sub-module: sat_cnt16 (16-bit saturating counter with inc/clr, clr priority), instantiated twice.

Test Plan:
- Reset and lock-in: 5 clean frames (header 32'hA5C3_0100..0104, 64 payload words {8'h00, B=12'h800+i, A=12'h100+i}) -> 320 sample_valid strobes; first sample_a=12'h100, sample_b=12'h800; frame_start once per frame; locked rises after the 4th good frame; ctrl_word=8'h01; both counters 0.
- Garbage then sync: 10 words of 32'hDEADBEEF before a header -> no samples, no error count, clean lock afterwards.
- Bad payload word at word 20 of a locked frame (top byte 8'h5A) -> locked=0 next cycle, frame_err_cnt=1, FSM HUNT, no sample for that word; relock after 4 good frames.
- Sequence skip: headers seq 0x10 then 0x12 -> seq_err_cnt=1, locked stays 1, samples continue.
- FIFO empty gaps: toggle fifo_empty every 3 cycles mid-frame -> sample count and order unchanged; every sample_valid is exactly 2 cycles after its fifo_rd_en.
- Counter edges: force frame_err_cnt to 16'hFFFF via 65535 short frames (or a forced preload) then one more error -> stays 16'hFFFF; clr_cnt coincident with an error -> counter reads 0.
